// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle log-shifter for the ALU datapath. One operand/shamt/op triple
//   is accepted through a valid/ready handshake. It is then resolved over five
//   clocks, with one power-of-two stage (1,2,4,8,16) per clock. The 32-bit
//   result is presented through a second valid/ready handshake. SLL, SRL and
//   SRA share the same stage logic.
//
// Ports
//   clk      in   1       single clock, rising edge
//   rst_n    in   1       asynchronous active-low reset
//   i_valid  in   1       upstream offers in/shamt/op
//   i_ready  out  1       high only in IDLE
//   in       in   N       operand
//   shamt    in   STAGES  unsigned shift amount
//   op       in   2       00=SLL, 01=SRL, 11=SRA, 10=reserved (acts as SRL)
//   o_valid  out  1       high only in DONE
//   o_ready  in   1       downstream accepts result
//   out      out  N       shifted result, held after the output handshake
//   busy     out  1       high in BUSY or DONE
module shift_sequencer #(
  parameter int N      = 32,
  parameter int STAGES = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [N-1:0]      in,
  input  logic [STAGES-1:0] shamt,
  input  logic [1:0]        op,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [N-1:0]      out,
  output logic              busy
);

  localparam int CW = $clog2(STAGES);
  localparam logic [CW-1:0] LAST = CW'(STAGES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      work;
  logic [STAGES-1:0] shamt_q;
  logic [1:0]        op_q;
  logic              sign_q;
  logic [N-1:0]      work_nxt;

  // One log-shifter stage: shift by 2**k. For SRA, the vacated MSBs are
  // filled with the sign captured at accept time.
  function automatic logic [N-1:0] shift_stage(
    input logic [N-1:0]  w,
    input logic [CW-1:0] k,
    input logic [1:0]    o,
    input logic          s
  );
    logic [N-1:0] ones;
    logic [N-1:0] fill;
    int           amt;
    ones = '1;
    amt  = 1 << k;
    fill = s ? ~(ones >> amt) : '0;
    case (o)
      2'b00:   shift_stage = w << amt;
      2'b11:   shift_stage = (w >> amt) | fill;
      default: shift_stage = w >> amt;
    endcase
  endfunction

  always_comb begin
    work_nxt = work;
    if (shamt_q[cnt]) work_nxt = shift_stage(work, cnt, op_q, sign_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      work    <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      out     <= '0;
      i_ready <= 1'b1;
      o_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            work    <= in;
            shamt_q <= shamt;
            op_q    <= op;
            sign_q  <= in[N-1];
            cnt     <= '0;
            state   <= BUSY;
            i_ready <= 1'b0;
            busy    <= 1'b1;
          end
        end
        BUSY: begin
          // Every stage is walked, even when shamt is 0, so latency is fixed.
          work <= work_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt     <= '0;
            out     <= work_nxt;
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          i_ready <= 1'b1;
          o_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready = 1'b0;
  logic        i_ready;
  logic        o_valid;
  logic        busy;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [4:0]  shamt = '0;
  logic [1:0]  op = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.N(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .in      (din),
    .shamt   (shamt),
    .op      (op),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .out     (dout),
    .busy    (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [1:0]  op;
    int          stall;
    logic [31:0] exp;
  } vec_t;

  // Reference: plain language shift operators on the whole operand.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s,
                                        input logic [1:0] o);
    case (o)
      2'b00:   model = a << s;
      2'b11:   model = 32'($signed(a) >>> s);
      default: model = a >> s;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation and drain it. While junk is set, the task also
  // drives noise on i_valid, operands and o_ready outside the legal windows.
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o,
                        input int stall, input bit junk, input string tag,
                        output logic [31:0] res);
    int w;
    int lat;
    logic [31:0] held;
    w = 0;
    while (!i_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check({tag, " i_ready idle"}, 32'(i_ready), 32'd1);
    din = a; shamt = s; op = o; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    check({tag, " i_ready after accept"}, 32'(i_ready), 32'd0);
    lat = 0;
    while (!o_valid && lat < 20) begin
      if (junk) begin
        i_valid = 1'($urandom); din = $urandom; shamt = 5'($urandom);
        op = 2'($urandom); o_ready = 1'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    o_ready = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd5);
    res = dout;
    held = dout;
    for (int i = 0; i < stall; i++) begin
      if (junk) begin
        i_valid = 1'b1; din = $urandom; shamt = 5'($urandom); op = 2'($urandom);
      end
      @(posedge clk); #1;
      check({tag, " stall o_valid"}, 32'(o_valid), 32'd1);
      check({tag, " stall out"}, dout, held);
      check({tag, " stall i_ready"}, 32'(i_ready), 32'd0);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    check({tag, " o_valid drop"}, 32'(o_valid), 32'd0);
    check({tag, " out held"}, dout, held);
    check({tag, " i_ready back"}, 32'(i_ready), 32'd1);
    check({tag, " busy clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    logic [31:0] res;
    logic [31:0] a;
    logic [4:0]  s;
    logic [1:0]  o;

    tbl[0] = '{32'h0000_0001, 5'd31, 2'b00, 0, 32'h8000_0000};
    tbl[1] = '{32'h8000_0000, 5'd4,  2'b11, 0, 32'hF800_0000};
    tbl[2] = '{32'h8000_0000, 5'd4,  2'b01, 0, 32'h0800_0000};
    tbl[3] = '{32'h8000_0000, 5'd4,  2'b10, 0, 32'h0800_0000};
    tbl[4] = '{32'hDEAD_BEEF, 5'd0,  2'b00, 0, 32'hDEAD_BEEF};
    tbl[5] = '{32'hDEAD_BEEF, 5'd0,  2'b01, 1, 32'hDEAD_BEEF};
    tbl[6] = '{32'hDEAD_BEEF, 5'd0,  2'b11, 0, 32'hDEAD_BEEF};
    tbl[7] = '{32'h1234_5678, 5'd8,  2'b00, 3, 32'h3456_7800};
    tbl[8] = '{32'h8765_4321, 5'd31, 2'b11, 0, 32'hFFFF_FFFF};

    // Reset state
    #12;
    check("reset i_ready", 32'(i_ready), 32'd1);
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset out", dout, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle i_ready", 32'(i_ready), 32'd1);

    foreach (tbl[k]) begin
      run_op(tbl[k].a, tbl[k].sh, tbl[k].op, tbl[k].stall, 1'b0, $sformatf("vec%0d", k), res);
      check($sformatf("vec%0d out", k), res, tbl[k].exp);
    end

    // Backpressure with new requests and noise offered during BUSY and DONE
    run_op(32'hF000_000F, 5'd3, 2'b11, 3, 1'b1, "bp", res);
    check("bp out", res, 32'hFE00_0001);

    // Reset pulse while BUSY at cnt=2. The previous result is nonzero.
    din = 32'hCAFE_F00D; shamt = 5'd7; op = 2'b00; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst o_valid", 32'(o_valid), 32'd0);
    check("midrst out", dout, 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst i_ready", 32'(i_ready), 32'd1);
    check("midrst busy idle", 32'(busy), 32'd0);
    check("midrst no o_valid", 32'(o_valid), 32'd0);
    run_op(32'h0000_00FF, 5'd4, 2'b00, 0, 1'b0, "postrst", res);
    check("postrst out", res, 32'h0000_0FF0);

    // Random regression
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      s = 5'($urandom_range(0, 31));
      o = 2'($urandom_range(0, 3));
      run_op(a, s, o, $urandom_range(0, 3), 1'b1, "rnd", res);
      check($sformatf("rnd%0d a=%08h s=%0d op=%0d", n, a, s, o), res, model(a, s, o));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
